// File: rtl/input_event_controller_pkg.sv
// Event codes, drain FSM states and helpers shared by the front-panel input controller.
// Codes are 1-based; pending bit (code-1) holds code.
package input_event_controller_pkg;

  localparam int unsigned CODE_W = 4;

  localparam logic [CODE_W-1:0] EV_NONE        = 4'd0;
  localparam logic [CODE_W-1:0] EV_CON_PRESS   = 4'd1;
  localparam logic [CODE_W-1:0] EV_CON_RELEASE = 4'd2;
  localparam logic [CODE_W-1:0] EV_PSH_PRESS   = 4'd3;
  localparam logic [CODE_W-1:0] EV_PSH_RELEASE = 4'd4;
  localparam logic [CODE_W-1:0] EV_BAK_PRESS   = 4'd5;
  localparam logic [CODE_W-1:0] EV_BAK_RELEASE = 4'd6;
  localparam logic [CODE_W-1:0] EV_ENC_CW      = 4'd7;
  localparam logic [CODE_W-1:0] EV_ENC_CCW     = 4'd8;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } drain_state_t;

  // Lowest set pending bit wins, so simultaneous events drain in code order.
  function automatic logic [CODE_W-1:0] lowest_code(input logic [7:0] pending);
    lowest_code = EV_NONE;
    for (int i = 7; i >= 0; i--) begin
      if (pending[i]) lowest_code = CODE_W'(i + 1);
    end
  endfunction

endpackage

// File: rtl/input_event_controller_debouncer.sv
// Per-pin 2-flop synchroniser and tick-sampled debouncer with 1-cycle rise/fall pulses.
// Idle level is high, so releasing reset never produces a pulse.
module input_event_controller_debouncer #(
  parameter int unsigned DEBOUNCE_COUNT = 4
) (
  input  logic clk,
  input  logic nreset,
  input  logic tick,
  input  logic in,
  output logic stable,
  output logic rise,
  output logic fall
);

  localparam logic [3:0] CNT_LAST = 4'(DEBOUNCE_COUNT - 1);

  logic [1:0] sync;
  logic [3:0] cnt;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      sync   <= 2'b11;
      stable <= 1'b1;
      cnt    <= 4'd0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync <= {sync[0], in};
      rise <= 1'b0;
      fall <= 1'b0;
      if (tick) begin
        if (sync[1] == stable) begin
          cnt <= 4'd0;
        end else if (cnt == CNT_LAST) begin
          stable <= sync[1];
          cnt    <= 4'd0;
          rise   <= sync[1];
          fall   <= ~sync[1];
        end else begin
          cnt <= cnt + 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/input_event_controller.sv
// Front-panel scanner: debounced buttons and encoder become event codes queued in a FWFT FIFO.
//   state | meaning
//   IDLE  | no pending events
//   DRAIN | pushing the lowest pending code into the FIFO, one per clk
module input_event_controller
  import input_event_controller_pkg::*;
#(
  parameter int unsigned SCAN_BITS       = 16,
  parameter int unsigned DEBOUNCE_COUNT  = 4,
  parameter int unsigned FIFO_DEPTH_BITS = 3
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic       con_button,
  input  logic       psh_button,
  input  logic       bak_button,
  input  logic       tra,
  input  logic       trb,
  input  logic       rd,
  input  logic       clr_overflow,
  input  logic       irq_enable,
  output logic [7:0] data_out,
  output logic       event_valid,
  output logic       irq,
  output logic       overflow
);

  localparam int unsigned DEPTH = 1 << FIFO_DEPTH_BITS;

  logic [SCAN_BITS-1:0] tick_cnt;
  logic                 tick;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) tick_cnt <= '0;
    else         tick_cnt <= tick_cnt - SCAN_BITS'(1);
  end

  assign tick = (tick_cnt == '0);

  logic [4:0] pin_raw, pin_stable, pin_rise, pin_fall;
  assign pin_raw = {trb, tra, bak_button, psh_button, con_button};

  for (genvar g = 0; g < 5; g++) begin : g_deb
    input_event_controller_debouncer #(
      .DEBOUNCE_COUNT(DEBOUNCE_COUNT)
    ) u_deb (
      .clk   (clk),
      .nreset(nreset),
      .tick  (tick),
      .in    (pin_raw[g]),
      .stable(pin_stable[g]),
      .rise  (pin_rise[g]),
      .fall  (pin_fall[g])
    );
  end

  logic unused_edges;
  assign unused_edges = ^{pin_fall[4:3], pin_rise[4], pin_stable[3:0]};

  // Encoder counts only on the TRA rising edge; TRB level selects direction.
  logic [7:0] ev;
  assign ev = {pin_rise[3] & pin_stable[4],
               pin_rise[3] & ~pin_stable[4],
               pin_rise[2], pin_fall[2],
               pin_rise[1], pin_fall[1],
               pin_rise[0], pin_fall[0]};

  drain_state_t      state;
  logic [7:0]        pending, clr_mask;
  logic [CODE_W-1:0] head_code, push_code;
  logic              push_vld;

  assign head_code = lowest_code(pending);

  always_comb begin
    clr_mask = 8'h00;
    if (state == DRAIN && pending != 8'h00) clr_mask = 8'(1) << (head_code - 4'd1);
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state     <= IDLE;
      pending   <= 8'h00;
      push_vld  <= 1'b0;
      push_code <= EV_NONE;
    end else begin
      pending  <= (pending & ~clr_mask) | ev;
      push_vld <= 1'b0;
      case (state)
        IDLE: begin
          if (pending != 8'h00) state <= DRAIN;
        end
        DRAIN: begin
          if (pending != 8'h00) begin
            push_vld  <= 1'b1;
            push_code <= head_code;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic [FIFO_DEPTH_BITS:0] wr_ptr, rd_ptr;
  logic [CODE_W-1:0]        mem [DEPTH];
  logic                     empty, full, pop, wr_en, drop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[FIFO_DEPTH_BITS] != rd_ptr[FIFO_DEPTH_BITS]) &&
                 (wr_ptr[FIFO_DEPTH_BITS-1:0] == rd_ptr[FIFO_DEPTH_BITS-1:0]);
  assign pop   = rd && event_valid && !empty;
  assign wr_en = push_vld && (!full || pop);
  assign drop  = push_vld && full && !pop;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[FIFO_DEPTH_BITS-1:0]] <= push_code;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      event_valid <= 1'b0;
      data_out    <= 8'h00;
      overflow    <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      event_valid <= !empty;
      data_out    <= empty ? 8'h00 : {{(8 - CODE_W){1'b0}}, mem[rd_ptr[FIFO_DEPTH_BITS-1:0]]};
      if (drop)              overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;
    end
  end

  assign irq = event_valid & irq_enable;

endmodule
